// File: rtl/txdata_pkt_fifo.sv
// Single-clock packet-aware TX data FIFO with store-and-forward/cut-through,
// abort rewind and overflow drop. Optional stats via TXPKTFIFO_STATS_EN.
module txdata_pkt_fifo #(
  parameter int WIDTH    = 256,
  parameter int PTR      = 10,
  parameter int DEPTH    = 1024,
  parameter int SAF      = 1,
  parameter int AFULL_TH = 992
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wren,
  input  logic [WIDTH-1:0] datain,
  input  logic             wreop,
  input  logic             wrabort,
  output logic             wrfull,
  output logic             wralmostfull,
  output logic [PTR:0]     wrusedw,
  input  logic             rden,
  output logic [WIDTH-1:0] dataout,
  output logic             rdeop,
  output logic             rdvalid,
  output logic             rdempty,
  output logic [PTR:0]     rdusedw,
  output logic [PTR:0]     rdpktcnt,
  output logic             dbg
`ifdef TXPKTFIFO_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      abort_cnt,
  output logic [PTR:0]     peak_usedw
`endif
);

  localparam logic [PTR:0] ONE     = (PTR+1)'(1);
  localparam logic [PTR:0] DEPTH_W = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] TH_W    = (PTR+1)'(AFULL_TH);
  localparam bit           SAF_ON  = (SAF != 0);

  logic [WIDTH:0] mem [DEPTH];

  logic [PTR:0] wr_ptr;
  logic [PTR:0] cm_ptr;
  logic [PTR:0] rd_ptr;
  logic         ovf;

  logic         wr_ok;
  logic         ovf_now;
  logic         eop_w;
  logic         drop;
  logic         pkt_in;
  logic         rd_ok;
  logic         rd_eop;
  logic [WIDTH:0] rd_word;

  logic [PTR:0] wr_ptr_nx;
  logic [PTR:0] cm_ptr_nx;
  logic         ovf_nx;

  assign wrusedw      = wr_ptr - rd_ptr;
  assign rdusedw      = cm_ptr - rd_ptr;
  assign wrfull       = (wrusedw == DEPTH_W);
  assign wralmostfull = (wrusedw >= TH_W);
  assign rdempty      = (cm_ptr == rd_ptr);

  // A write that meets a full FIFO taints the rest of its packet,
  // including an EOP word arriving on that same cycle.
  assign wr_ok   = wren & ~wrfull & ~wrabort;
  assign ovf_now = ovf | (wren & wrfull);
  assign eop_w   = wren & wreop & ~wrabort;
  assign drop    = SAF_ON & eop_w & ovf_now;
  assign pkt_in  = wr_ok & wreop & ~drop;

  assign rd_ok   = rden & ~rdempty;
  assign rd_word = mem[rd_ptr[PTR-1:0]];
  assign rd_eop  = rd_ok & rd_word[WIDTH];

  always_comb begin
    wr_ptr_nx = wr_ptr;
    cm_ptr_nx = cm_ptr;
    ovf_nx    = ovf_now;
    if (wrabort) begin
      ovf_nx = 1'b0;
      if (SAF_ON)
        wr_ptr_nx = cm_ptr;
    end else begin
      if (eop_w)
        ovf_nx = 1'b0;
      if (drop)
        wr_ptr_nx = cm_ptr;
      else if (wr_ok)
        wr_ptr_nx = wr_ptr + ONE;
    end
    if (SAF_ON) begin
      if (pkt_in)
        cm_ptr_nx = wr_ptr + ONE;
    end else if (wr_ok) begin
      cm_ptr_nx = wr_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr[PTR-1:0]] <= {wreop, datain};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
      dbg      <= 1'b0;
      rdpktcnt <= '0;
      dataout  <= '0;
      rdeop    <= 1'b0;
      rdvalid  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nx;
      cm_ptr  <= cm_ptr_nx;
      ovf     <= ovf_nx;
      rdvalid <= rd_ok;
      if (drop)
        dbg <= 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + ONE;
        dataout <= rd_word[WIDTH-1:0];
        rdeop   <= rd_word[WIDTH];
      end
      if (pkt_in & ~rd_eop)
        rdpktcnt <= rdpktcnt + ONE;
      else if (rd_eop & ~pkt_in)
        rdpktcnt <= rdpktcnt - ONE;
    end
  end

`ifdef TXPKTFIFO_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt   <= '0;
      abort_cnt  <= '0;
      peak_usedw <= '0;
    end else if (stats_clr) begin
      drop_cnt   <= '0;
      abort_cnt  <= '0;
      peak_usedw <= '0;
    end else begin
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 16'd1;
      if (wrabort && abort_cnt != '1)
        abort_cnt <= abort_cnt + 16'd1;
      if (wrusedw > peak_usedw)
        peak_usedw <= wrusedw;
    end
  end
`endif

endmodule

// File: tb/tb_txdata_pkt_fifo.sv
// Bench: one store-and-forward and one cut-through FIFO (DEPTH=16) share
// stimulus and are compared every cycle against queue-based packet models.
module tb_txdata_pkt_fifo;
  localparam int W  = 16;
  localparam int P  = 4;
  localparam int D  = 16;
  localparam int TH = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wren = 1'b0;
  logic         wreop = 1'b0;
  logic         wrabort = 1'b0;
  logic         rden = 1'b0;
  logic [W-1:0] datain = '0;

  logic         a_full, a_afull, a_eop, a_val, a_empty, a_dbg;
  logic [P:0]   a_wused, a_rused, a_pkts;
  logic [W-1:0] a_dout;
  logic         b_full, b_afull, b_eop, b_val, b_empty, b_dbg;
  logic [P:0]   b_wused, b_rused, b_pkts;
  logic [W-1:0] b_dout;
`ifdef TXPKTFIFO_STATS_EN
  logic         stats_clr = 1'b0;
  logic [15:0]  a_drops, a_aborts, b_drops, b_aborts;
  logic [P:0]   a_peak, b_peak;
`endif

  always #5 clk = ~clk;

  txdata_pkt_fifo #(
    .WIDTH(W), .PTR(P), .DEPTH(D), .SAF(1), .AFULL_TH(TH)
  ) u_saf (
    .clk(clk), .reset(reset), .wren(wren), .datain(datain),
    .wreop(wreop), .wrabort(wrabort), .wrfull(a_full),
    .wralmostfull(a_afull), .wrusedw(a_wused), .rden(rden),
    .dataout(a_dout), .rdeop(a_eop), .rdvalid(a_val),
    .rdempty(a_empty), .rdusedw(a_rused), .rdpktcnt(a_pkts),
    .dbg(a_dbg)
`ifdef TXPKTFIFO_STATS_EN
    , .stats_clr(stats_clr), .drop_cnt(a_drops),
    .abort_cnt(a_aborts), .peak_usedw(a_peak)
`endif
  );

  txdata_pkt_fifo #(
    .WIDTH(W), .PTR(P), .DEPTH(D), .SAF(0), .AFULL_TH(TH)
  ) u_ct (
    .clk(clk), .reset(reset), .wren(wren), .datain(datain),
    .wreop(wreop), .wrabort(wrabort), .wrfull(b_full),
    .wralmostfull(b_afull), .wrusedw(b_wused), .rden(rden),
    .dataout(b_dout), .rdeop(b_eop), .rdvalid(b_val),
    .rdempty(b_empty), .rdusedw(b_rused), .rdpktcnt(b_pkts),
    .dbg(b_dbg)
`ifdef TXPKTFIFO_STATS_EN
    , .stats_clr(stats_clr), .drop_cnt(b_drops),
    .abort_cnt(b_aborts), .peak_usedw(b_peak)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model A (store-and-forward): committed queue plus open packet.
  logic [W:0]   cma[$];
  logic [W:0]   pda[$];
  bit           ovfa, dbga, vala, eopa;
  logic [W-1:0] douta;
  // Model B (cut-through): every accepted word is readable.
  logic [W:0]   cmb[$];
  bit           valb, eopb;
  logic [W-1:0] doutb;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_eop(input logic [W:0] q[$]);
    int n = 0;
    foreach (q[i]) if (q[i][W]) n++;
    return n;
  endfunction

  task automatic model_reset();
    cma.delete(); pda.delete(); cmb.delete();
    ovfa = 0; dbga = 0; vala = 0; eopa = 0; douta = '0;
    valb = 0; eopb = 0; doutb = '0;
  endtask

  task automatic model_step(input bit we, input logic [W-1:0] d,
                            input bit eo, input bit ab, input bit re);
    int  ua, ub;
    bit  fa, fb, ov;
    ua = cma.size() + pda.size();
    ub = cmb.size();
    fa = (ua == D);
    fb = (ub == D);
    vala = 0;
    if (re && cma.size() > 0) begin
      {eopa, douta} = cma.pop_front();
      vala = 1;
    end
    valb = 0;
    if (re && cmb.size() > 0) begin
      {eopb, doutb} = cmb.pop_front();
      valb = 1;
    end
    if (ab) begin
      pda.delete();
      ovfa = 0;
    end else if (we) begin
      ov = ovfa | fa;
      if (!fa) pda.push_back({eo, d});
      if (eo) begin
        if (ov) dbga = 1;
        else foreach (pda[i]) cma.push_back(pda[i]);
        pda.delete();
        ovfa = 0;
      end else begin
        ovfa = ov;
      end
      if (!fb) cmb.push_back({eo, d});
    end
  endtask

  task automatic check_all();
    int ua;
    ua = cma.size() + pda.size();
    chk("a_wrusedw", 32'(a_wused), ua);
    chk("a_rdusedw", 32'(a_rused), cma.size());
    chk("a_rdpktcnt", 32'(a_pkts), n_eop(cma));
    chk("a_wrfull", 32'(a_full), 32'(ua == D));
    chk("a_almostfull", 32'(a_afull), 32'(ua >= TH));
    chk("a_rdempty", 32'(a_empty), 32'(cma.size() == 0));
    chk("a_dbg", 32'(a_dbg), 32'(dbga));
    chk("a_rdvalid", 32'(a_val), 32'(vala));
    chk("a_rdeop", 32'(a_eop), 32'(eopa));
    chk("a_dataout", 32'(a_dout), 32'(douta));
    chk("b_wrusedw", 32'(b_wused), cmb.size());
    chk("b_rdusedw", 32'(b_rused), cmb.size());
    chk("b_rdpktcnt", 32'(b_pkts), n_eop(cmb));
    chk("b_wrfull", 32'(b_full), 32'(cmb.size() == D));
    chk("b_almostfull", 32'(b_afull), 32'(cmb.size() >= TH));
    chk("b_rdempty", 32'(b_empty), 32'(cmb.size() == 0));
    chk("b_dbg", 32'(b_dbg), 32'd0);
    chk("b_rdvalid", 32'(b_val), 32'(valb));
    chk("b_rdeop", 32'(b_eop), 32'(eopb));
    chk("b_dataout", 32'(b_dout), 32'(doutb));
  endtask

  // Called just after a falling edge; ends just after the next one.
  task automatic step(input bit we, input logic [W-1:0] d, input bit eo,
                      input bit ab, input bit re);
    wren = we; datain = d; wreop = eo; wrabort = ab; rden = re;
    model_step(we, d, eo, ab, re);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
  endtask

  task automatic rd(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 1);
  endtask

  initial begin
    int ep, rp;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // 4-word packet, then read it out
    for (int i = 1; i <= 4; i++) step(1, W'(16'h100 + i), i == 4, 0, 0);
    chk("pkt4_rdusedw", 32'(a_rused), 32'd4);
    chk("pkt4_rdpktcnt", 32'(a_pkts), 32'd1);
    rd(4);
    chk("pkt4_last_eop", 32'(a_eop), 32'd1);
    idle(1);
    chk("pkt4_pktcnt_end", 32'(a_pkts), 32'd0);

    // abort with a simultaneous write
    for (int i = 1; i <= 3; i++) step(1, W'(16'h200 + i), 0, 0, 0);
    step(1, 16'h2ff, 0, 1, 0);
    chk("abort_wrusedw", 32'(a_wused), 32'd0);
    chk("abort_dbg", 32'(a_dbg), 32'd0);
    rd(4);

    // 20-word packet overflows a 16-deep FIFO
    for (int i = 1; i <= 20; i++) begin
      step(1, W'(16'h300 + i), i == 20, 0, 0);
      if (i == 16) chk("ovf_wrfull", 32'(a_full), 32'd1);
    end
    chk("ovf_wrusedw", 32'(a_wused), 32'd0);
    chk("ovf_dbg", 32'(a_dbg), 32'd1);
    rd(17);
    step(1, 16'h4a1, 0, 0, 0);
    step(1, 16'h4a2, 1, 0, 0);
    rd(1);
    chk("after_ovf_word1", 32'(a_dout), 32'h4a1);
    rd(2);

    // randomized traffic across packet-length / read-rate regimes
    for (int ph = 0; ph < 6; ph++) begin
      ep = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 8 : 3);
      rp = (ph < 3) ? 70 : 25;
      for (int i = 0; i < 400; i++)
        step($urandom % 100 < 85, W'($urandom), $urandom % 100 < ep,
             $urandom % 100 < 2, $urandom % 100 < rp);
    end
    step(1, W'($urandom), 1, 0, 0);
    rd(40);
    chk("idle_used_eq", 32'(a_wused), 32'(a_rused));

    // reset mid-packet with 5 committed words
    for (int i = 1; i <= 5; i++) step(1, W'(16'h500 + i), i == 5, 0, 0);
    step(1, 16'h5a0, 0, 0, 0);
    step(1, 16'h5a1, 0, 0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2;
    reset = 1'b0;
    step(1, 16'h6c3, 1, 0, 0);
    rd(1);
    chk("post_reset_data", 32'(a_dout), 32'h6c3);
    chk("post_reset_eop", 32'(a_eop), 32'd1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
